// File: rtl/uart_ext_if.sv
// Bus-side interface of uart_ext: TX valid/ready handshake plus RX FIFO read port.
// The register file uses the master modport and the UART uses the slave modport.
interface uart_ext_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_pop;
  logic [CW-1:0]        rx_count;

  modport master (
    output tx_valid, tx_data, rx_pop,
    input  tx_ready, rx_data, rx_valid, rx_count
  );
  modport slave (
    input  tx_valid, tx_data, rx_pop,
    output tx_ready, rx_data, rx_valid, rx_count
  );
endinterface

// File: rtl/uart_ext.sv
// UART with parity/stop options, RX FIFO with sticky errors and RTS/CTS flow control.
// Define UART_LOOPBACK_EN to add loopback_i, which routes internal TX into RX and idles the pad.
module uart_ext #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int BAUD_W     = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BAUD_W-1:0] baud_div_i,
  input  logic              parity_en_i,
  input  logic              parity_odd_i,
  input  logic              two_stop_i,
  input  logic              cts_n_i,
  input  logic              rx_i,
  input  logic              err_clear_i,
`ifdef UART_LOOPBACK_EN
  input  logic              loopback_i,
`endif
  output logic              tx_o,
  output logic              rts_o,
  output logic              frame_err_o,
  output logic              parity_err_o,
  output logic              overrun_o,
  uart_ext_if.slave         bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = 4;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  // ---------------- TX ----------------
  state_e               tx_state_q, tx_state_d;
  logic [BAUD_W-1:0]    tx_div_q, tx_div_d, tx_cnt_q, tx_cnt_d;
  logic                 tx_half_q, tx_half_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d, tx_par_en_q, tx_par_en_d, tx_two_q, tx_two_d;
  logic                 tx_bit_end, tx_line;

  // A bit period is two half-bit spans of (div+1) cycles each.
  assign tx_bit_end = tx_half_q && (tx_cnt_q == tx_div_q);

  // NOTE: every signal written here gets a default first, so no latches are inferred.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_div_d    = tx_div_q;
    tx_cnt_d    = tx_cnt_q;
    tx_half_d   = tx_half_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_par_d    = tx_par_q;
    tx_par_en_d = tx_par_en_q;
    tx_two_d    = tx_two_q;
    if (tx_state_q != S_IDLE) begin
      if (tx_cnt_q == tx_div_q) begin
        tx_cnt_d  = '0;
        tx_half_d = ~tx_half_q;
      end else begin
        tx_cnt_d = tx_cnt_q + 1'b1;
      end
    end
    case (tx_state_q)
      S_IDLE: if (bus.tx_valid && !cts_n_i) begin
        tx_state_d  = S_START;
        tx_shift_d  = bus.tx_data;
        tx_par_d    = (^bus.tx_data) ^ parity_odd_i;
        tx_par_en_d = parity_en_i;
        tx_two_d    = two_stop_i;
        tx_div_d    = baud_div_i;
        tx_cnt_d    = '0;
        tx_half_d   = 1'b0;
        tx_bit_d    = '0;
      end
      S_START: if (tx_bit_end) tx_state_d = S_DATA;
      S_DATA: if (tx_bit_end) begin
        tx_shift_d = tx_shift_q >> 1;
        if (tx_bit_q == LAST_BIT) begin
          tx_bit_d   = '0;
          tx_state_d = tx_par_en_q ? S_PARITY : S_STOP;
        end else begin
          tx_bit_d = tx_bit_q + 1'b1;
        end
      end
      S_PARITY: if (tx_bit_end) tx_state_d = S_STOP;
      S_STOP: if (tx_bit_end) begin
        if (tx_two_q && tx_bit_q == '0) begin
          tx_bit_d = BW'(1);
        end else begin
          tx_bit_d   = '0;
          tx_state_d = S_IDLE;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q  <= S_IDLE;
      tx_div_q    <= '0;
      tx_cnt_q    <= '0;
      tx_half_q   <= 1'b0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_par_q    <= 1'b0;
      tx_par_en_q <= 1'b0;
      tx_two_q    <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_div_q    <= tx_div_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_half_q   <= tx_half_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_par_q    <= tx_par_d;
      tx_par_en_q <= tx_par_en_d;
      tx_two_q    <= tx_two_d;
    end
  end

  assign tx_line = (tx_state_q == S_START)  ? 1'b0 :
                   (tx_state_q == S_DATA)   ? tx_shift_q[0] :
                   (tx_state_q == S_PARITY) ? tx_par_q : 1'b1;
  assign bus.tx_ready = (tx_state_q == S_IDLE);

  // ---------------- RX ----------------
  logic rx_src, rx_meta_q, rx_sync_q;
`ifdef UART_LOOPBACK_EN
  assign rx_src = loopback_i ? tx_line : rx_i;
  assign tx_o   = loopback_i ? 1'b1 : tx_line;
`else
  assign rx_src = rx_i;
  assign tx_o   = tx_line;
`endif

  state_e               rx_state_q, rx_state_d;
  logic [BAUD_W-1:0]    rx_div_q, rx_div_d, rx_cnt_q, rx_cnt_d;
  logic                 rx_half_q, rx_half_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d, rx_par_en_q, rx_par_en_d, rx_odd_q, rx_odd_d;
  logic                 rx_mid, push, set_fe, set_pe, set_ov, full, pop_ok;

  // Start bit samples at the end of its first half; later bits one full period on.
  assign rx_mid = (rx_cnt_q == rx_div_q) && (rx_half_q == (rx_state_q != S_START));

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_div_d    = rx_div_q;
    rx_cnt_d    = rx_cnt_q;
    rx_half_d   = rx_half_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_par_d    = rx_par_q;
    rx_par_en_d = rx_par_en_q;
    rx_odd_d    = rx_odd_q;
    push        = 1'b0;
    set_fe      = 1'b0;
    set_pe      = 1'b0;
    set_ov      = 1'b0;
    if (rx_state_q != S_IDLE) begin
      if (rx_cnt_q == rx_div_q) begin
        rx_cnt_d  = '0;
        rx_half_d = ~rx_half_q;
      end else begin
        rx_cnt_d = rx_cnt_q + 1'b1;
      end
    end
    case (rx_state_q)
      S_IDLE: if (!rx_sync_q) begin
        rx_state_d  = S_START;
        rx_div_d    = baud_div_i;
        rx_par_en_d = parity_en_i;
        rx_odd_d    = parity_odd_i;
        rx_cnt_d    = '0;
        rx_half_d   = 1'b0;
        rx_bit_d    = '0;
      end
      S_START: if (rx_mid) begin
        rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
        rx_half_d  = 1'b0;
      end
      S_DATA: if (rx_mid) begin
        rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
        if (rx_bit_q == LAST_BIT) begin
          rx_bit_d   = '0;
          rx_state_d = rx_par_en_q ? S_PARITY : S_STOP;
        end else begin
          rx_bit_d = rx_bit_q + 1'b1;
        end
      end
      S_PARITY: if (rx_mid) begin
        rx_par_d   = rx_sync_q;
        rx_state_d = S_STOP;
      end
      S_STOP: if (rx_mid) begin
        rx_state_d = S_IDLE;
        if (!rx_sync_q)                                                  set_fe = 1'b1;
        else if (rx_par_en_q && (rx_par_q != ((^rx_shift_q) ^ rx_odd_q))) set_pe = 1'b1;
        else if (full && !bus.rx_pop)                                    set_ov = 1'b1;
        else                                                             push   = 1'b1;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_state_q  <= S_IDLE;
      rx_div_q    <= '0;
      rx_cnt_q    <= '0;
      rx_half_q   <= 1'b0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_par_q    <= 1'b0;
      rx_par_en_q <= 1'b0;
      rx_odd_q    <= 1'b0;
    end else begin
      rx_meta_q   <= rx_src;
      rx_sync_q   <= rx_meta_q;
      rx_state_q  <= rx_state_d;
      rx_div_q    <= rx_div_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_half_q   <= rx_half_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_par_q    <= rx_par_d;
      rx_par_en_q <= rx_par_en_d;
      rx_odd_q    <= rx_odd_d;
    end
  end

  // ---------------- FIFO and flags ----------------
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;

  assign full   = (count_q == CW'(FIFO_DEPTH));
  assign pop_ok = bus.rx_pop && (count_q != '0);

  // NOTE: storage has no reset; rx_data is masked to 0 while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_shift_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop_ok)      count_q <= count_q + 1'b1;
      else if (!push && pop_ok) count_q <= count_q - 1'b1;
      if (err_clear_i) begin
        frame_err_o  <= 1'b0;
        parity_err_o <= 1'b0;
        overrun_o    <= 1'b0;
      end else begin
        if (set_fe) frame_err_o  <= 1'b1;
        if (set_pe) parity_err_o <= 1'b1;
        if (set_ov) overrun_o    <= 1'b1;
      end
    end
  end

  assign bus.rx_data  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign bus.rx_valid = (count_q != '0);
  assign bus.rx_count = count_q;
  assign rts_o        = (count_q >= CW'(FIFO_DEPTH - 1));
endmodule

// File: tb/tb_uart_ext.sv
// Directed self-checking bench for uart_ext (8 data bits, 4-entry FIFO, baud_div=3 -> 8 clk/bit).
// Build with UART_LOOPBACK_EN defined to also exercise the loopback path.
module tb_uart_ext;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] baud_div = 12'd3;
  logic        parity_en = 1'b0, parity_odd = 1'b0, two_stop = 1'b0;
  logic        cts_n = 1'b0, rx = 1'b1, err_clear = 1'b0;
  logic        tx, rts, frame_err, parity_err, overrun;
`ifdef UART_LOOPBACK_EN
  logic        loopback = 1'b0;
`endif
  int checks = 0;
  int errors = 0;

  uart_ext_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus ();

  uart_ext #(.DATA_BITS(8), .FIFO_DEPTH(4), .BAUD_W(12)) dut (
    .clk(clk), .rst(rst), .baud_div_i(baud_div), .parity_en_i(parity_en),
    .parity_odd_i(parity_odd), .two_stop_i(two_stop), .cts_n_i(cts_n), .rx_i(rx),
    .err_clear_i(err_clear),
`ifdef UART_LOOPBACK_EN
    .loopback_i(loopback),
`endif
    .tx_o(tx), .rts_o(rts), .frame_err_o(frame_err), .parity_err_o(parity_err),
    .overrun_o(overrun), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one TX word, then record the line at each mid-bit and the busy length.
  task automatic tx_frame(input logic [7:0] d, output logic [11:0] bits, output int busy);
    bits = '0;
    busy = 0;
    @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    @(posedge clk);
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) bus.tx_valid = 1'b0;
      if (bus.tx_ready) break;
      busy++;
      if (n % 8 == 4 && n / 8 < 12) bits[n/8] = tx;
    end
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    rx = b;
    repeat (7) @(negedge clk);
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic par_en, input logic par_bit,
                          input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (par_en) drive_bit(par_bit);
    drive_bit(stop_bit);
    @(negedge clk);
    rx = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    @(negedge clk);
    check(tag, bus.rx_data, exp);
    bus.rx_pop = 1'b1;
    @(negedge clk);
    bus.rx_pop = 1'b0;
  endtask

  task automatic clear_flags();
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] bits;
    int          busy;
    int          low_seen;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    bus.rx_pop   = 1'b0;

    #12;
    check("rst_tx", tx, 1'b1);
    check("rst_tx_ready", bus.tx_ready, 1'b1);
    check("rst_rx_valid", bus.rx_valid, 1'b0);
    check("rst_rx_count", bus.rx_count, 0);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_flags", {frame_err, parity_err, overrun}, 3'b000);
    check("rst_rts", rts, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // 8N1 0xA5: start, 1010 0101 LSB first, stop -> {1,A5,0}
    tx_frame(8'hA5, bits, busy);
    check("tx_8n1_bits", bits[9:0], 10'h34A);
    check("tx_8n1_busy", busy, 80);

    parity_en = 1'b1;
    tx_frame(8'hA5, bits, busy);
    check("tx_even_bits", bits[10:0], 11'h54A);
    check("tx_even_busy", busy, 88);
    parity_odd = 1'b1;
    tx_frame(8'hA5, bits, busy);
    check("tx_odd_bits", bits[10:0], 11'h74A);
    parity_en = 1'b0;
    parity_odd = 1'b0;

    two_stop = 1'b1;
    tx_frame(8'h3C, bits, busy);
    check("tx_8n2_bits", bits[10:0], 11'h678);
    check("tx_8n2_busy", busy, 88);
    two_stop = 1'b0;

    // CTS blocks a pending frame until it drops
    @(negedge clk);
    cts_n = 1'b1;
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h5A;
    repeat (20) @(negedge clk);
    check("cts_hold_tx", tx, 1'b1);
    check("cts_hold_ready", bus.tx_ready, 1'b1);
    cts_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    check("cts_start_bit", tx, 1'b0);
    check("cts_busy", bus.tx_ready, 1'b0);
    begin
      int n = 0;
      while (!bus.tx_ready && n < 200) begin @(negedge clk); n++; end
      check("cts_frame_done", bus.tx_ready, 1'b1);
    end

    // RX fill: rts asserts at three entries, overrun on the fifth frame
    rx_frame(8'h11, 1'b0, 1'b0, 1'b1);
    rx_frame(8'h22, 1'b0, 1'b0, 1'b1);
    check("rx_count_2", bus.rx_count, 2);
    check("rts_at_2", rts, 1'b0);
    rx_frame(8'h33, 1'b0, 1'b0, 1'b1);
    check("rts_at_3", rts, 1'b1);
    rx_frame(8'h44, 1'b0, 1'b0, 1'b1);
    check("rx_count_4", bus.rx_count, 4);
    check("overrun_before", overrun, 1'b0);
    rx_frame(8'h55, 1'b0, 1'b0, 1'b1);
    check("overrun_set", overrun, 1'b1);
    check("overrun_count", bus.rx_count, 4);
    check("overrun_other_flags", {frame_err, parity_err}, 2'b00);
    pop_check("pop_1", 8'h11);
    pop_check("pop_2", 8'h22);
    pop_check("pop_3", 8'h33);
    pop_check("pop_4", 8'h44);
    check("fifo_empty", {bus.rx_valid, bus.rx_count}, 4'b0000);
    check("overrun_sticky", overrun, 1'b1);
    clear_flags();
    check("overrun_cleared", overrun, 1'b0);

    // Bad stop bit, then a short glitch on idle
    rx_frame(8'h69, 1'b0, 1'b0, 1'b0);
    check("frame_err_set", frame_err, 1'b1);
    check("frame_err_nopush", bus.rx_count, 0);
    clear_flags();
    @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_nopush", bus.rx_count, 0);
    check("glitch_noflag", {frame_err, parity_err, overrun}, 3'b000);

    // Parity: 0x07 even -> bit 1 accepted; 0xA5 even with bit 1 -> error
    parity_en = 1'b1;
    rx_frame(8'h07, 1'b1, 1'b1, 1'b1);
    check("par_good_count", bus.rx_count, 1);
    pop_check("par_good_data", 8'h07);
    rx_frame(8'hA5, 1'b1, 1'b1, 1'b1);
    check("par_err_set", parity_err, 1'b1);
    check("par_err_nopush", bus.rx_count, 0);
    parity_en = 1'b0;
    clear_flags();

    // Reset mid-DATA with one RX entry held
    rx_frame(8'h9C, 1'b0, 1'b0, 1'b1);
    check("pre_rst_count", bus.rx_count, 1);
    @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h00;
    @(posedge clk);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_rst_tx_low", tx, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_tx", tx, 1'b1);
    check("mid_rst_ready", bus.tx_ready, 1'b1);
    check("mid_rst_fifo", {bus.rx_valid, bus.rx_count}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

`ifdef UART_LOOPBACK_EN
    @(negedge clk);
    loopback = 1'b1;
    two_stop = 1'b1;
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h3C;
    @(posedge clk);
    low_seen = 0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (n == 1) bus.tx_valid = 1'b0;
      if (tx == 1'b0) low_seen++;
      if (bus.rx_valid && bus.tx_ready) break;
    end
    check("lb_pad_idle", low_seen, 0);
    check("lb_rx_valid", bus.rx_valid, 1'b1);
    check("lb_rx_data", bus.rx_data, 8'h3C);
    loopback = 1'b0;
    two_stop = 1'b0;
`else
    low_seen = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_ext.md
Name: uart_ext

Overview:
Parametrised second-generation UART for the MCU peripheral bus.
- Configurable data width, optional parity, 1 or 2 stop bits.
- RX receive FIFO with sticky error flags; valid/ready TX handshake.
- RTS/CTS hardware flow control.
- Sits between the bus register file (which drives config and pops RX data) and the chip pads.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
FIFO_DEPTH, 4, RX FIFO entries; must be a power of 2, at least 2.
BAUD_W, 12, width of the baud divider and the bit-timing counters.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous reset, active-high.
baud_div  input  BAUD_W  half-bit divider; one bit period = 2*(baud_div+1) clk cycles.
parity_en  input  1  1 = parity bit present after the data bits.
parity_odd  input  1  1 = odd parity, 0 = even; ignored when parity_en=0.
two_stop  input  1  1 = two stop bits on TX (RX checks only the first stop bit).
tx_valid  input  1  TX data offered.
tx_data  input  DATA_BITS  TX data, sent LSB first.
tx_ready  output  1  transmitter accepts tx_data this cycle.
tx  output  1  serial out; idle level is 1.
cts_n  input  1  clear-to-send, active-low; 1 blocks new TX frames.
rx  input  1  serial in, asynchronous to clk.
rts  output  1  request-to-send.
rx_data  output  DATA_BITS  FIFO head.
rx_valid  output  1  FIFO not empty.
rx_pop  input  1  remove the head entry; ignored when the FIFO is empty.
rx_count  output  $clog2(FIFO_DEPTH)+1  number of FIFO entries.
frame_err  output  1  sticky flag: stop bit sampled as 0.
parity_err  output  1  sticky flag: parity mismatch.
overrun  output  1  sticky flag: frame dropped because the FIFO was full.
err_clear  input  1  clears all three sticky flags.

Behaviour:
Reset and configuration
- Reset (async, any time, including mid-frame):
  - tx=1, tx_ready=1.
  - Both FSMs go to IDLE.
  - FIFO empty: rx_valid=0, rx_count=0, rx_data=0.
  - All sticky flags are 0.
  - rts=0.
  - All counters are 0.
- Config inputs are sampled at frame start. Changing them mid-frame has no effect until the next frame.

TX path
- FSM states: IDLE -> START -> DATA -> PARITY (only if parity_en) -> STOP -> IDLE.
- Each state lasts one bit period per bit. STOP lasts 1 bit, or 2 bits when two_stop=1.
- tx_ready = 1 only in IDLE.
- A transfer is accepted when tx_valid && tx_ready && !cts_n. tx_data is latched on that edge.
- tx goes 0 (start bit) on the following cycle.
- If cts_n=1, the frame waits in IDLE with tx_ready held at 1 and nothing is latched.
- cts_n changing mid-frame does not abort the frame.
- Parity bit = XOR of the data bits, XOR parity_odd.
- tx_ready returns to 1 on the cycle after the last stop bit ends.
- Total frame length = (1 + DATA_BITS + parity_en + 1 + two_stop) bit periods.

RX path
- rx passes through a 2-flop synchroniser. The FSM sees the synchronised signal only.
- FSM states: IDLE -> START -> DATA -> PARITY (if parity_en) -> STOP -> IDLE.
- IDLE: a low level starts the bit timer.
- Mid-bit sampling: each bit is sampled once its half-bit counter reaches baud_div, i.e. (baud_div+1) cycles into the bit.
- If the start bit samples as 1, it is a false start: return to IDLE with no push and no flag.
- DATA bits are shifted LSB first.
- At the STOP sample, exactly one of the following happens:
  - stop=0: set frame_err; discard the frame.
  - parity mismatch: set parity_err; discard the frame.
  - FIFO full and no rx_pop this cycle: set overrun; discard the frame.
  - otherwise: push the frame into the FIFO.
- After the STOP sample, return to IDLE immediately. The next start bit may begin half a bit later.

FIFO and flow control
- Push and pop in the same cycle:
  - If the FIFO is full, both are accepted and rx_count is unchanged.
  - If the FIFO is empty, the pop is ignored and the push is accepted.
- rx_data always shows the head entry, with no read latency. Pointers wrap modulo FIFO_DEPTH.
- rts = 1 when rx_count >= FIFO_DEPTH-1, i.e. "stop sending to me".
- Sticky flags: err_clear has priority over a set in the same cycle.

Optional Feature:
UART_LOOPBACK_EN
- Defined:
  - Adds input port loopback (1 bit).
  - When loopback=1, the RX synchroniser input is the internal tx signal.
  - The pad tx is held at 1 and the external rx is ignored.
- Undefined: the port is absent; RX is always driven from the rx pad.

Test Plan:
- baud_div=3 (bit = 8 clk), 8N1, tx_data=0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each held 8 cycles; tx_ready low for 80 cycles, then high.
- Parity even vs odd, 0xA5 (four 1s) -> parity bit 0 when parity_odd=0, 1 when parity_odd=1; RX injects a wrong parity bit -> parity_err=1, rx_count stays 0.
- RX four frames 0x11,0x22,0x33,0x44 with FIFO_DEPTH=4 -> rts=1 after the 3rd frame, rx_count=4; a 5th frame 0x55 -> overrun=1; pops return 0x11..0x44 in order; err_clear -> overrun=0.
- RX stop bit forced to 0 -> frame_err=1, no push. A 2-clk low glitch on idle rx -> no push, no flag.
- cts_n=1 with tx_valid=1 -> tx stays 1, tx_ready stays 1; drop cts_n to 0 -> start bit on the next cycle. Assert rst mid-DATA -> tx=1 and tx_ready=1 immediately, FIFO empty.
- UART_LOOPBACK_EN defined, loopback=1, two_stop=1, send 0x3C -> rx_data=0x3C with rx_valid=1; pad tx stays 1 throughout.
